pcs_rx_block_sync: RTL and testbench
====================================

# pcs_rx_block_sync

Receive-side 10GBASE-R PCS block: takes 66-bit blocks from the SerDes gearbox, acquires and monitors 64b/66b block lock, descrambles the payload, and decodes it onto the XGMII receive bus. It is the counterpart of the transmit-path encoder/scrambler, and drives RXD/RXC/RXVALID/LOCK on the XGMII interface toward the MAC.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive valid sync headers required to declare lock.
- BAD_SH_MAX, 16: invalid headers within a 64-block window that drop lock.

Ports:
- TX_CLK  in  1  single clock; all logic on rising edge.
- rstn_as_i  in  1  asynchronous active-low reset.
- rx_blk  in  66  block from gearbox; [1:0] sync header, [65:2] payload, bit 0 first received.
- rx_blk_vld  in  1  rx_blk valid this cycle.
- slip  out  1  one-cycle pulse: gearbox shifts block boundary by one bit.
- RXD  out  64  decoded XGMII data; lane n = bits [8n+7:8n].
- RXC  out  8  XGMII control, bit n for lane n.
- RXVALID  out  1  RXD/RXC valid.
- LOCK  out  1  block lock achieved.
- bad_sh_cnt  out  16  saturating count of invalid headers seen while LOCK=1.

## Operation
- Header: rx_blk[1:0]==2'b10 data, 2'b01 control, 2'b00/2'b11 invalid.
- Lock FSM, advances only on rx_blk_vld=1:
  - HUNT: valid header increments sh_cnt; sh_cnt reaching LOCK_CNT -> LOCKED, LOCK=1, counters cleared. Invalid header -> SLIP.
  - SLIP: slip=1 for one cycle, counters cleared -> WAIT.
  - WAIT: discard next 2 valid blocks (gearbox settle) -> HUNT.
  - LOCKED: 64-block window; invalid header increments bad_cnt and bad_sh_cnt. bad_cnt reaching BAD_SH_MAX -> LOCK=0, SLIP. Window end with bad_cnt<BAD_SH_MAX -> window and bad_cnt cleared.
- Decode (control blocks use payload[7:0] as type):
  - Data: RXD=payload, RXC=8'h00.
  - 0x1E with all eight 7-bit codes zero: RXD=64'h0707070707070707, RXC=8'hFF.
  - 0x78 start: lane0=8'hFB, lanes1-7=payload[63:8], RXC=8'h01.
  - 0x87 T0: lane0=8'hFD, lanes1-7=8'h07, RXC=8'hFF.
  - 0xFF T7: lanes0-6=payload[63:8], lane7=8'hFD, RXC=8'h80.
  - Any other type, invalid header, or 0x1E with nonzero codes: all lanes 8'hFE, RXC=8'hFF.
- While LOCK=0: each valid input yields local-fault output RXD=64'h0100009C_0100009C, RXC=8'h11.
- bad_sh_cnt saturates at 16'hFFFF; cleared only by reset.

## Timing
- Reset: LOCK=0, slip=0, RXVALID=0, RXD=0, RXC=0, bad_sh_cnt=0, FSM=HUNT, descrambler state=0.
- Latency: rx_blk_vld at cycle N -> RXVALID=1 at N+2 (stage1 descramble, stage2 decode); RXVALID is rx_blk_vld delayed 2, gaps preserved.
- LOCK rises registered, same cycle as RXVALID for the LOCK_CNT-th valid block; first decoded (non-fault) output is the next block.
- LOCK falls with the output of the block that reached BAD_SH_MAX; that block and later output local fault.
- slip is asserted the cycle after the offending block is sampled; never on consecutive cycles.
- Invalid header on a decoded block outputs error even while LOCKED.
- Reset asserted mid-operation clears all state immediately; pipeline contents dropped.

## Configuration
- PCS_DESCRAMBLE_EN defined: payload descrambled with self-synchronous x^58+x^39+1: out[i]=in[i]^s[38]^s[57], received scrambled bits shifted into s, bit 2 first; state updates on every valid block regardless of lock.
- Undefined: payload passed through unchanged (scrambler bypass test mode); latency unchanged at 2 cycles.

## Test plan
- Reset then 64 idle blocks (hdr 01, type 0x1E, zero codes) -> LOCK=1 after 64th; block 65 gives RXD=64'h0707070707070707, RXC=8'hFF at +2 cycles.
- Locked, start block then data block 64'h1122334455667788 -> RXD lane0=8'hFB RXC=8'h01, then RXD=64'h1122334455667788 RXC=8'h00.
- Locked, 16 headers 2'b11 within one window -> LOCK=0, one slip pulse, bad_sh_cnt=16, RXD=64'h0100009C_0100009C, RXC=8'h11.
- Locked, 15 invalid headers per window over 3 windows -> LOCK stays 1, bad_sh_cnt=45, each invalid block outputs all 8'hFE.
- HUNT with invalid header after 10 valid -> slip pulse, next 2 blocks ignored, 64 further valid needed for LOCK.
- With PCS_DESCRAMBLE_EN, scrambled idle stream from reference scrambler -> idle decode after lock; rx_blk_vld gaps reproduced exactly on RXVALID.

Source files
------------

// File: rtl/pcs_rx_block_sync.sv
// pcs_rx_block_sync: 10GBASE-R receive block lock, descramble and XGMII decode.
//   TX_CLK      clock, rising edge
//   rstn_as_i   asynchronous active-low reset
//   rx_blk      66-bit block, [1:0] sync header, [65:2] payload
//   rx_blk_vld  rx_blk valid this cycle
//   slip        one-cycle request to shift the gearbox boundary by one bit
//   RXD/RXC     decoded XGMII data/control, RXVALID marks them valid
//   LOCK        block lock, aligned with the output of the block that changed it
//   bad_sh_cnt  saturating count of invalid headers seen while locked
//   Define PCS_DESCRAMBLE_EN to enable the x^58+x^39+1 descrambler; otherwise
//   the payload passes through unchanged with the same two-cycle latency.
module pcs_rx_block_sync #(
  parameter int LOCK_CNT   = 64,
  parameter int BAD_SH_MAX = 16
) (
  input  logic        TX_CLK,
  input  logic        rstn_as_i,
  input  logic [65:0] rx_blk,
  input  logic        rx_blk_vld,
  output logic        slip,
  output logic [63:0] RXD,
  output logic [7:0]  RXC,
  output logic        RXVALID,
  output logic        LOCK,
  output logic [15:0] bad_sh_cnt
);
  localparam logic [15:0] LC = 16'(LOCK_CNT - 1);
  localparam logic [15:0] BM = 16'(BAD_SH_MAX - 1);
  typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCKED} state_t;
  state_t st, st_n;
  logic [15:0] cnt, cnt_n, bad, bad_n;
  logic [63:0] dsc, p1;
  logic [1:0]  h1;
  logic        v1, lb1, la1;
  logic [71:0] dec;
  logic        sh_ok;
  assign sh_ok = rx_blk[0] ^ rx_blk[1];
  assign slip  = st == SLIP;
`ifdef PCS_DESCRAMBLE_EN
  logic [57:0] scr, scr_n;
  // Self-synchronous: the received (scrambled) bits feed the state, bit 2 first.
  always_comb begin
    dsc   = '0;
    scr_n = scr;
    for (int i = 0; i < 64; i++) begin
      dsc[i] = rx_blk[i+2] ^ scr_n[38] ^ scr_n[57];
      scr_n  = {scr_n[56:0], rx_blk[i+2]};
    end
  end
  always_ff @(posedge TX_CLK or negedge rstn_as_i)
    if (!rstn_as_i) scr <= '0;
    else if (rx_blk_vld) scr <= scr_n;
`else
  assign dsc = rx_blk[65:2];
`endif
  // cnt is the header run in HUNT, the settle count in WAIT and the window position in LOCKED.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    bad_n = bad;
    if (st == SLIP) begin
      st_n  = WAIT;
      cnt_n = '0;
      bad_n = '0;
    end else if (rx_blk_vld) begin
      case (st)
        HUNT:
          if (!sh_ok) st_n = SLIP;
          else if (cnt == LC) begin
            st_n  = LOCKED;
            cnt_n = '0;
            bad_n = '0;
          end else cnt_n = cnt + 16'd1;
        WAIT: begin
          st_n  = cnt == 16'd1 ? HUNT : WAIT;
          cnt_n = cnt == 16'd1 ? 16'd0 : cnt + 16'd1;
        end
        LOCKED:
          if (!sh_ok && bad == BM) st_n = SLIP;
          else begin
            bad_n = cnt == 16'd63 ? 16'd0 : bad + 16'(!sh_ok);
            cnt_n = cnt == 16'd63 ? 16'd0 : cnt + 16'd1;
          end
        default: ;
      endcase
    end
  end
  // Decoded output only when locked both before and after this block.
  always_comb begin
    dec = {8'hFF, {8{8'hFE}}};
    if (!(lb1 && la1)) dec = {8'h11, 64'h0100009C_0100009C};
    else if (h1 == 2'b10) dec = {8'h00, p1};
    else if (h1 == 2'b01)
      dec = p1[7:0] == 8'h1E && p1[63:8] == 56'd0 ? {8'hFF, {8{8'h07}}} :
            p1[7:0] == 8'h78 ? {8'h01, p1[63:8], 8'hFB} :
            p1[7:0] == 8'h87 ? {8'hFF, {7{8'h07}}, 8'hFD} :
            p1[7:0] == 8'hFF ? {8'h80, 8'hFD, p1[63:8]} :
            {8'hFF, {8{8'hFE}}};
  end
  always_ff @(posedge TX_CLK or negedge rstn_as_i)
    if (!rstn_as_i) begin
      st         <= HUNT;
      cnt        <= '0;
      bad        <= '0;
      bad_sh_cnt <= '0;
      v1         <= 1'b0;
      h1         <= '0;
      p1         <= '0;
      lb1        <= 1'b0;
      la1        <= 1'b0;
      RXVALID    <= 1'b0;
      RXD        <= '0;
      RXC        <= '0;
      LOCK       <= 1'b0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      bad <= bad_n;
      if (rx_blk_vld && st == LOCKED && !sh_ok && ~&bad_sh_cnt) bad_sh_cnt <= bad_sh_cnt + 16'd1;
      v1 <= rx_blk_vld;
      if (rx_blk_vld) begin
        h1  <= rx_blk[1:0];
        p1  <= dsc;
        lb1 <= st == LOCKED;
        la1 <= st_n == LOCKED;
      end
      RXVALID <= v1;
      if (v1) begin
        {RXC, RXD} <= dec;
        LOCK       <= la1;
      end
    end
endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// tb_pcs_rx_block_sync: table and sequence checks of lock, decode and timing via an output scoreboard.
module tb_pcs_rx_block_sync;
  logic        TX_CLK = 1'b0;
  logic        rstn = 1'b0;
  logic [65:0] rx_blk = '0;
  logic        rx_blk_vld = 1'b0;
  logic        slip, RXVALID, LOCK;
  logic [63:0] RXD;
  logic [7:0]  RXC;
  logic [15:0] bad_sh_cnt;
  localparam logic [63:0] IDLE_P = 64'h1E;
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] LF_D   = 64'h0100009C_0100009C;
  localparam logic [63:0] FE_D   = 64'hFEFEFEFEFEFEFEFE;
  typedef struct {logic [63:0] d; logic [7:0] c; logic l;} exp_t;
  typedef struct {logic [1:0] h; logic [63:0] p; logic [63:0] d; logic [7:0] c;} vec_t;
  exp_t        q[$];
  vec_t        tbl[10];
  int          cmp = 0, err = 0, slip_cnt = 0;
  logic        slip_prev = 1'b0;
  logic [1:0]  hist = '0;
  logic [57:0] sc = '0;
  pcs_rx_block_sync dut (
    .TX_CLK(TX_CLK), .rstn_as_i(rstn), .rx_blk(rx_blk), .rx_blk_vld(rx_blk_vld),
    .slip(slip), .RXD(RXD), .RXC(RXC), .RXVALID(RXVALID), .LOCK(LOCK), .bad_sh_cnt(bad_sh_cnt)
  );
  always #5 TX_CLK = ~TX_CLK;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // Payloads are scrambled by a reference scrambler when the descrambler is built in.
  task automatic send(input logic [1:0] h, input logic [63:0] p, input logic [63:0] d,
                      input logic [7:0] c, input logic l);
    logic [63:0] o;
    o = p;
`ifdef PCS_DESCRAMBLE_EN
    for (int i = 0; i < 64; i++) begin
      o[i] = p[i] ^ sc[38] ^ sc[57];
      sc   = {sc[56:0], o[i]};
    end
`endif
    rx_blk     = {o, h};
    rx_blk_vld = 1'b1;
    q.push_back('{d, c, l});
    @(posedge TX_CLK);
    #1;
    rx_blk_vld = 1'b0;
  endtask
  task automatic gap();
    rx_blk_vld = 1'b0;
    @(posedge TX_CLK);
    #1;
  endtask
  task automatic drain();
    repeat (4) @(posedge TX_CLK);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  task automatic do_reset();
    rstn       = 1'b0;
    rx_blk_vld = 1'b0;
    @(negedge TX_CLK);
    chk("rst_lock", 64'(LOCK), 64'd0);
    chk("rst_slip", 64'(slip), 64'd0);
    chk("rst_rxvalid", 64'(RXVALID), 64'd0);
    chk("rst_rxd", RXD, 64'd0);
    chk("rst_rxc", 64'(RXC), 64'd0);
    chk("rst_badcnt", 64'(bad_sh_cnt), 64'd0);
    q.delete();
    sc        = '0;
    slip_cnt  = 0;
    slip_prev = 1'b0;
    @(posedge TX_CLK);
    #1;
    rstn = 1'b1;
  endtask
  task automatic relock();
    do_reset();
    repeat (63) send(2'b01, IDLE_P, LF_D, 8'h11, 1'b0);
    send(2'b01, IDLE_P, LF_D, 8'h11, 1'b1);
  endtask
  // Output monitor: RXVALID must be the input valid two edges late; every output pops the scoreboard.
  initial forever begin
    @(negedge TX_CLK);
    if (!rstn) hist = '0;
    else begin
      chk("rxvalid_delay", 64'(RXVALID), 64'(hist[1]));
      if (RXVALID) begin
        if (q.size() == 0) begin
          cmp++;
          err++;
          $display("FAIL unexpected_output: got RXD %h with empty scoreboard", RXD);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rxd", RXD, e.d);
          chk("rxc", 64'(RXC), 64'(e.c));
          chk("lock", 64'(LOCK), 64'(e.l));
        end
      end
      if (slip) begin
        slip_cnt++;
        chk("slip_consecutive", 64'(slip_prev), 64'd0);
      end
      slip_prev = slip;
      hist = {hist[0], rx_blk_vld};
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{2'b01, IDLE_P, IDLE_D, 8'hFF};
    tbl[1] = '{2'b01, 64'hD555555555555578, 64'hD5555555555555FB, 8'h01};
    tbl[2] = '{2'b10, 64'h1122334455667788, 64'h1122334455667788, 8'h00};
    tbl[3] = '{2'b01, 64'h1234567890ABCD87, 64'h07070707070707FD, 8'hFF};
    tbl[4] = '{2'b01, 64'hAABBCCDDEEFF00FF, 64'hFDAABBCCDDEEFF00, 8'h80};
    tbl[5] = '{2'b01, 64'h0000000000000055, FE_D, 8'hFF};
    tbl[6] = '{2'b01, 64'h000000000000011E, FE_D, 8'hFF};
    tbl[7] = '{2'b00, 64'h1122334455667788, FE_D, 8'hFF};
    tbl[8] = '{2'b11, IDLE_P, FE_D, 8'hFF};
    tbl[9] = '{2'b10, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h00};
    relock();
    send(2'b01, IDLE_P, IDLE_D, 8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].h, tbl[i].p, tbl[i].d, tbl[i].c, 1'b1);
      if (i % 3 == 2) gap();
    end
    drain();
    chk("table_badcnt", 64'(bad_sh_cnt), 64'd2);
    chk("table_lock", 64'(LOCK), 64'd1);
    relock();
    for (int w = 0; w < 3; w++) begin
      repeat (15) send(2'b11, IDLE_P, FE_D, 8'hFF, 1'b1);
      for (int k = 0; k < 49; k++) begin
        send(2'b01, IDLE_P, IDLE_D, 8'hFF, 1'b1);
        if (w == 1 && k == 20) gap();
      end
    end
    drain();
    chk("win_badcnt", 64'(bad_sh_cnt), 64'd45);
    chk("win_lock", 64'(LOCK), 64'd1);
    chk("win_slips", 64'(slip_cnt), 64'd0);
    relock();
    repeat (15) send(2'b11, IDLE_P, FE_D, 8'hFF, 1'b1);
    send(2'b11, IDLE_P, LF_D, 8'h11, 1'b0);
    repeat (3) send(2'b01, IDLE_P, LF_D, 8'h11, 1'b0);
    drain();
    chk("drop_badcnt", 64'(bad_sh_cnt), 64'd16);
    chk("drop_lock", 64'(LOCK), 64'd0);
    chk("drop_slips", 64'(slip_cnt), 64'd1);
    do_reset();
    repeat (10) send(2'b01, IDLE_P, LF_D, 8'h11, 1'b0);
    send(2'b11, IDLE_P, LF_D, 8'h11, 1'b0);
    @(negedge TX_CLK);
    chk("hunt_slip_pulse", 64'(slip), 64'd1);
    @(posedge TX_CLK);
    #1;
    repeat (65) send(2'b01, IDLE_P, LF_D, 8'h11, 1'b0);
    send(2'b01, IDLE_P, LF_D, 8'h11, 1'b1);
    send(2'b01, IDLE_P, IDLE_D, 8'hFF, 1'b1);
    drain();
    chk("hunt_slips", 64'(slip_cnt), 64'd1);
    chk("hunt_lock", 64'(LOCK), 64'd1);
    relock();
    send(2'b01, IDLE_P, IDLE_D, 8'hFF, 1'b1);
    send(2'b10, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 8'h00, 1'b1);
    do_reset();
    repeat (4) @(posedge TX_CLK);
    #1;
    chk("midrst_lock", 64'(LOCK), 64'd0);
    chk("midrst_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
